// File: rtl/uart_rx_fifo.sv
// uart_rx_fifo: receive-side byte FIFO between the UART m_axis output and
// the CSR block. Flow control is by drop-and-flag, never by back-pressure.
//
// Ports:
//   clk_i, rst_i      clock, asynchronous active-high reset
//   s_tdata_i/_tvalid_i/s_tready_o   byte stream from the UART receiver
//   rd_i              pop strobe (CSR UART_DATA read)
//   rd_data_o         head byte, show-ahead, 8'h00 when empty
//   not_empty_o, full_o, level_o     registered fill status
//   overrun_o, overrun_clr_i         sticky drop flag and its clear strobe
//   thresh_irq_o      one-cycle strobe when the fill level reaches THRESHOLD
module uart_rx_fifo #(
    parameter int DEPTH     = 16,
    parameter int THRESHOLD = 8
) (
    input  logic                   clk_i,
    input  logic                   rst_i,
    input  logic [7:0]             s_tdata_i,
    input  logic                   s_tvalid_i,
    output logic                   s_tready_o,
    input  logic                   rd_i,
    output logic [7:0]             rd_data_o,
    output logic                   not_empty_o,
    output logic                   full_o,
    output logic [$clog2(DEPTH):0] level_o,
    output logic                   overrun_o,
    input  logic                   overrun_clr_i,
    output logic                   thresh_irq_o
);

    localparam int AW = $clog2(DEPTH);
    localparam int LW = AW + 1;
    localparam logic [LW-1:0] FULL_LVL = LW'(DEPTH);
    localparam logic [LW-1:0] THR_LVL  = LW'(THRESHOLD);

    logic [7:0]    mem_q [DEPTH];
    logic [AW-1:0] wptr_q, wptr_d;
    logic [AW-1:0] rptr_q, rptr_d;
    logic [LW-1:0] level_q, level_d;
    logic          ready_q;
    logic          not_empty_q, full_q;
    logic          overrun_q, overrun_d;
    logic          thresh_q;
    logic          push, pop, drop;

    // ready_q is low during reset and on the first edge after release, so it
    // doubles as the gate that ignores all input strobes until then.
    always_comb begin
        pop       = ready_q && rd_i && (level_q != '0);
        push      = ready_q && s_tvalid_i && (!full_q || rd_i);
        drop      = ready_q && s_tvalid_i && full_q && !rd_i;
        wptr_d    = push ? wptr_q + AW'(1) : wptr_q;
        rptr_d    = pop  ? rptr_q + AW'(1) : rptr_q;
        level_d   = level_q;
        case ({push, pop})
            2'b10:   level_d = level_q + LW'(1);
            2'b01:   level_d = level_q - LW'(1);
            default: level_d = level_q;
        endcase
        // A drop in the same cycle as a clear leaves the flag set.
        overrun_d = overrun_q;
        if (ready_q && overrun_clr_i) overrun_d = 1'b0;
        if (drop)                     overrun_d = 1'b1;
    end

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            wptr_q      <= '0;
            rptr_q      <= '0;
            level_q     <= '0;
            ready_q     <= 1'b0;
            not_empty_q <= 1'b0;
            full_q      <= 1'b0;
            overrun_q   <= 1'b0;
            thresh_q    <= 1'b0;
        end else begin
            wptr_q      <= wptr_d;
            rptr_q      <= rptr_d;
            level_q     <= level_d;
            ready_q     <= 1'b1;
            not_empty_q <= (level_d != '0);
            full_q      <= (level_d == FULL_LVL);
            overrun_q   <= overrun_d;
            // Fires only on the crossing, so it re-arms once level drops below.
            thresh_q    <= (level_q < THR_LVL) && (level_d >= THR_LVL);
        end
    end

    // Storage is not reset; contents are only visible through valid pointers.
    always_ff @(posedge clk_i) begin
        if (push) mem_q[wptr_q] <= s_tdata_i;
    end

    assign s_tready_o   = ready_q;
    assign rd_data_o    = not_empty_q ? mem_q[rptr_q] : 8'h00;
    assign not_empty_o  = not_empty_q;
    assign full_o       = full_q;
    assign level_o      = level_q;
    assign overrun_o    = overrun_q;
    assign thresh_irq_o = thresh_q;

endmodule

// File: tb/tb_uart_rx_fifo.sv
// Directed testbench for uart_rx_fifo (DEPTH=16, THRESHOLD=8).
module tb_uart_rx_fifo;

    logic       clk = 1'b0;
    logic       rst;
    logic [7:0] s_tdata;
    logic       s_tvalid;
    logic       s_tready;
    logic       rd;
    logic [7:0] rd_data;
    logic       not_empty;
    logic       full;
    logic [4:0] level;
    logic       overrun;
    logic       overrun_clr;
    logic       thresh_irq;

    int unsigned checks   = 0;
    int unsigned failures = 0;
    int unsigned irq_cnt  = 0;

    always #5 clk = ~clk;

    uart_rx_fifo #(.DEPTH(16), .THRESHOLD(8)) dut (
        .clk_i         (clk),
        .rst_i         (rst),
        .s_tdata_i     (s_tdata),
        .s_tvalid_i    (s_tvalid),
        .s_tready_o    (s_tready),
        .rd_i          (rd),
        .rd_data_o     (rd_data),
        .not_empty_o   (not_empty),
        .full_o        (full),
        .level_o       (level),
        .overrun_o     (overrun),
        .overrun_clr_i (overrun_clr),
        .thresh_irq_o  (thresh_irq)
    );

    // Counts every cycle the interrupt strobe is high, sampled after the edge.
    always @(posedge clk) begin
        #1;
        if (thresh_irq === 1'b1) irq_cnt++;
    end

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    // Inputs change on the falling edge; each strobe spans one rising edge.
    task automatic push(input logic [7:0] b);
        @(negedge clk);
        s_tvalid = 1'b1;
        s_tdata  = b;
        @(negedge clk);
        s_tvalid = 1'b0;
    endtask

    task automatic pop();
        @(negedge clk);
        rd = 1'b1;
        @(negedge clk);
        rd = 1'b0;
    endtask

    task automatic push_pop(input logic [7:0] b);
        @(negedge clk);
        s_tvalid = 1'b1;
        s_tdata  = b;
        rd       = 1'b1;
        @(negedge clk);
        s_tvalid = 1'b0;
        rd       = 1'b0;
    endtask

    initial begin
        rst = 1'b1; s_tdata = 8'h00; s_tvalid = 1'b0; rd = 1'b0; overrun_clr = 1'b0;
        repeat (3) @(negedge clk);
        check_eq("rst_level",     32'(level), 0);
        check_eq("rst_not_empty", 32'(not_empty), 0);
        check_eq("rst_full",      32'(full), 0);
        check_eq("rst_overrun",   32'(overrun), 0);
        check_eq("rst_irq",       32'(thresh_irq), 0);
        check_eq("rst_tready",    32'(s_tready), 0);
        check_eq("rst_rd_data",   32'(rd_data), 0);

        // A push on the first edge after release must be ignored.
        rst = 1'b0; s_tvalid = 1'b1; s_tdata = 8'h99;
        @(negedge clk);
        s_tvalid = 1'b0;
        check_eq("first_edge_tready", 32'(s_tready), 1);
        check_eq("first_edge_level",  32'(level), 0);

        // Basic push/pop ordering.
        push(8'h41); push(8'h42); push(8'h43);
        check_eq("basic_level", 32'(level), 3);
        check_eq("basic_head",  32'(rd_data), 32'h41);
        pop();
        check_eq("basic_pop1", 32'(rd_data), 32'h42);
        pop();
        check_eq("basic_pop2", 32'(rd_data), 32'h43);
        pop();
        check_eq("basic_pop3", 32'(rd_data), 32'h00);
        check_eq("basic_empty", 32'(not_empty), 0);
        pop();
        check_eq("underflow_level", 32'(level), 0);

        // Threshold strobe: 0x10..0x19 pushed, 3 popped, 0x1A pushed.
        for (int i = 0; i < 8; i++) push(8'(8'h10 + i));
        check_eq("thr_level8", 32'(level), 8);
        check_eq("thr_irq_first", irq_cnt, 1);
        push(8'h18); push(8'h19);
        check_eq("thr_irq_at10", irq_cnt, 1);
        pop(); pop(); pop();
        check_eq("thr_level7", 32'(level), 7);
        push(8'h1A);
        check_eq("thr_irq_rearm", irq_cnt, 2);
        for (int i = 0; i < 8; i++) begin
            check_eq("thr_drain", 32'(rd_data), 32'(8'h13 + i));
            pop();
        end
        check_eq("thr_drained", 32'(level), 0);

        // Overflow: 17 pushes, the 17th (0x70) is dropped.
        for (int i = 0; i < 17; i++) push(8'(8'h60 + i));
        check_eq("ovf_full",    32'(full), 1);
        check_eq("ovf_level",   32'(level), 16);
        check_eq("ovf_overrun", 32'(overrun), 1);
        check_eq("ovf_irq",     irq_cnt, 3);
        @(negedge clk); overrun_clr = 1'b1;
        @(negedge clk); overrun_clr = 1'b0;
        check_eq("ovf_clear", 32'(overrun), 0);

        // Push with simultaneous pop while full is accepted.
        push_pop(8'h55);
        check_eq("fullrw_level",   32'(level), 16);
        check_eq("fullrw_overrun", 32'(overrun), 0);
        check_eq("fullrw_head",    32'(rd_data), 32'h61);
        for (int i = 0; i < 16; i++) begin
            check_eq("fullrw_drain", 32'(rd_data), (i < 15) ? 32'(8'h61 + i) : 32'h55);
            pop();
        end
        check_eq("fullrw_empty", 32'(not_empty), 0);

        // 40 push/pop pairs across the pointer wrap; first one also hits rd at empty.
        push_pop(8'h80);
        check_eq("wrap_empty_rd", 32'(level), 1);
        for (int i = 1; i < 40; i++) begin
            push_pop(8'(8'h80 + i));
            check_eq("wrap_data",  32'(rd_data), 32'(8'h80 + i));
            check_eq("wrap_level", 32'(level), 1);
        end
        pop();
        check_eq("wrap_end", 32'(level), 0);

        // Drop in the same cycle as a clear: the drop wins.
        for (int i = 0; i < 16; i++) push(8'(8'hA0 + i));
        @(negedge clk); s_tvalid = 1'b1; s_tdata = 8'hEE; overrun_clr = 1'b1;
        @(negedge clk); s_tvalid = 1'b0; overrun_clr = 1'b0;
        check_eq("clr_vs_drop", 32'(overrun), 1);
        check_eq("clr_vs_drop_head", 32'(rd_data), 32'hA0);

        // Asynchronous reset mid-stream at level 5.
        repeat (11) pop();
        check_eq("pre_rst_level", 32'(level), 5);
        @(negedge clk);
        #1 rst = 1'b1;
        #1;
        check_eq("arst_level",     32'(level), 0);
        check_eq("arst_not_empty", 32'(not_empty), 0);
        check_eq("arst_full",      32'(full), 0);
        check_eq("arst_overrun",   32'(overrun), 0);
        check_eq("arst_irq",       32'(thresh_irq), 0);
        check_eq("arst_tready",    32'(s_tready), 0);
        check_eq("arst_rd_data",   32'(rd_data), 0);
        @(negedge clk); rst = 1'b0;
        @(negedge clk);
        push(8'h33);
        check_eq("post_rst_head",  32'(rd_data), 32'h33);
        check_eq("post_rst_level", 32'(level), 1);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/uart_rx_fifo.md
UART_RX_FIFO -- requirements
Module: uart_rx_fifo

Interface
REQ-001 SHALL have parameter DEPTH, default 16: FIFO depth in bytes; power of two, 2..256.
REQ-002 SHALL have parameter THRESHOLD, default 8: fill level that fires thresh_irq_o; 1..DEPTH.
REQ-003 SHALL have port clk_i  input  1  system clock; the only clock; all state on rising edge.
REQ-004 SHALL have port rst_i  input  1  reset, asynchronous, active-high.
REQ-005 SHALL have port s_tdata_i  input  8  received byte from the uart m_axis output.
REQ-006 SHALL have port s_tvalid_i  input  1  byte valid, 1-cycle strobe per byte.
REQ-007 SHALL have port s_tready_o  output  1  ready to the uart.
REQ-008 SHALL have port rd_i  input  1  pop strobe from the CSR UART_DATA read.
REQ-009 SHALL have port rd_data_o  output  8  head byte (show-ahead).
REQ-010 SHALL have port not_empty_o  output  1  level_o != 0; drives UART_STATUS_RX_NOT_EMPTY.
REQ-011 SHALL have port full_o  output  1  level_o == DEPTH.
REQ-012 SHALL have port level_o  output  $clog2(DEPTH)+1  bytes stored.
REQ-013 SHALL have port overrun_o  output  1  sticky overflow flag.
REQ-014 SHALL have port overrun_clr_i  input  1  clear strobe for overrun_o.
REQ-015 SHALL have port thresh_irq_o  output  1  1-cycle strobe to Interrupt_Ctrl set input.

Function
REQ-016 SHALL store bytes in a DEPTH-entry circular buffer with read/write pointers of $clog2(DEPTH) bits that wrap modulo DEPTH without special casing.
REQ-017 SHALL drive s_tready_o high in every cycle after reset release; all flow control is by drop-and-flag, never by back-pressure.
REQ-018 SHALL accept a push (s_tvalid_i=1) when level_o < DEPTH, or when level_o == DEPTH and rd_i=1 in the same cycle.
REQ-019 SHALL drop a push when level_o == DEPTH and rd_i=0, with buffer, pointers and level unchanged.
REQ-020 SHALL ignore rd_i when level_o == 0: no pointer or level change, no underflow.
REQ-021 SHALL, on push and pop in the same cycle with level_o > 0, pop the head, store the new byte, and keep level_o unchanged.
REQ-022 SHALL, on push and rd_i with level_o == 0, store the byte, ignore rd_i, and set level_o to 1.
REQ-023 SHALL update level_o, not_empty_o and full_o as registers in the cycle after the causing edge; a pushed byte becomes visible one cycle after s_tvalid_i.
REQ-024 SHALL present rd_data_o = buffer[read pointer] when not_empty_o=1, and 8'h00 when empty.
REQ-025 SHALL make the next byte visible on rd_data_o in the cycle after a pop.
REQ-026 SHALL set overrun_o on the edge after a dropped push (REQ-019); it holds until overrun_clr_i.
REQ-027 SHALL clear overrun_o on the edge after overrun_clr_i; a drop in the same cycle as the clear wins, leaving overrun_o=1.
REQ-028 SHALL pulse thresh_irq_o high for exactly one cycle, the cycle after level goes from < THRESHOLD to >= THRESHOLD.
REQ-029 SHALL not re-fire thresh_irq_o while level stays >= THRESHOLD; it re-arms only after level drops below THRESHOLD.

Reset
REQ-030 SHALL, while rst_i=1 and independent of clk_i, force: pointers 0; level_o=0; not_empty_o=0; full_o=1'b0 (level_o != DEPTH); overrun_o=0; thresh_irq_o=0; s_tready_o=0; rd_data_o=8'h00.
REQ-031 SHALL discard any partially processed push or pop when reset asserts mid-operation; buffer contents need not be cleared.
REQ-032 SHALL ignore s_tvalid_i, rd_i and overrun_clr_i during reset and on the first edge after release; s_tready_o rises on that first edge.

Verification
REQ-033 SHALL cover: push 0x41,0x42,0x43 -> level_o=3, rd_data_o=0x41; three rd_i pulses -> 0x42, 0x43, then 0x00 with not_empty_o=0.
REQ-034 SHALL cover: 17 pushes with DEPTH=16 and no reads -> full_o=1, level_o=16, overrun_o=1; 17th byte absent; overrun_clr_i -> overrun_o=0.
REQ-035 SHALL cover: full, then push 0x55 together with rd_i -> level_o stays 16, overrun_o stays 0, 0x55 read last.
REQ-036 SHALL cover: 40 push/pop pairs crossing pointer wrap -> data read back in order, level_o never exceeds 1.
REQ-037 SHALL cover: THRESHOLD=8; pushes to 8 -> one thresh_irq_o pulse; push to 10 -> no pulse; pop to 7, push to 8 -> one pulse.
REQ-038 SHALL cover: rst_i asserted mid-stream with level_o=5 -> all outputs at REQ-030 values immediately, without a clock edge.
